load_align_unit: RTL and testbench
==================================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Parameters
REQ-001 SHALL have parameter XLEN, default 64, giving data width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 64, giving address width.
REQ-003 SHALL have parameter SUPPORT_MISALIGN, default 1; 1 = split boundary-crossing loads into two reads, 0 = flag them as errors.

Interface
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  load request present.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_funct3  in  3  RISC-V load funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
REQ-010 mem_req  out  1  memory read request, held until mem_rvalid.
REQ-011 mem_addr  out  ADDR_W  word-aligned read address (low log2(XLEN/8) bits zero).
REQ-012 mem_rvalid  in  1  read data valid.
REQ-013 mem_rdata  in  XLEN  read data, byte 0 at bits [7:0].
REQ-014 out_valid  out  1  one-cycle result strobe.
REQ-015 out_data  out  XLEN  extended load result.
REQ-016 out_err  out  1  qualified by out_valid; illegal funct3 or disallowed misalignment.

Function
REQ-017 SHALL implement states IDLE, RD0, RD1, DONE.
REQ-018 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1.
REQ-019 On accept: capture addr and funct3; off = addr mod (XLEN/8); size = 1 << funct3[1:0] bytes; cross = (off + size > XLEN/8).
REQ-020 Illegal funct3 (111; 011, 110 when XLEN=32) SHALL go directly to DONE with out_err=1 and out_data=0, with no memory access.
REQ-021 cross with SUPPORT_MISALIGN=0 SHALL behave as REQ-020.
REQ-022 Otherwise the unit SHALL go to RD0 and drive mem_req=1, mem_addr=addr with low bits cleared.
REQ-023 In RD0, on mem_rvalid: if cross, latch mem_rdata as lo, go to RD1 with mem_addr incremented by XLEN/8; else latch as lo, go to DONE.
REQ-024 In RD1, on mem_rvalid: latch mem_rdata as hi and go to DONE.
REQ-025 Result = bytes [off .. off+size-1] of the 2*XLEN concatenation {hi, lo}; hi is 0 when not crossing.
REQ-026 Extension: funct3[2]=0 SHALL sign-extend from the top selected bit; funct3[2]=1 SHALL zero-extend; size = XLEN/8 SHALL pass through unchanged.
REQ-027 DONE SHALL assert out_valid for exactly one cycle with registered out_data/out_err, then return to IDLE.
REQ-028 Latency: accept at cycle N; mem_req from N+1; mem_rvalid at cycle M SHALL give out_valid at M+1 (one-read case).
REQ-029 mem_rvalid outside RD0/RD1 SHALL be ignored.
REQ-030 out_data and out_err SHALL hold their last value when out_valid=0.
REQ-031 A new request SHALL be accepted in the cycle after DONE at the earliest.

Reset
REQ-032 While reset=0: state=IDLE, req_ready=1, mem_req=0, mem_addr=0, out_valid=0, out_data=0, out_err=0, captured registers=0.
REQ-033 Reset asserted mid-transaction SHALL abort it; a mem_rvalid arriving after reset release SHALL be ignored per REQ-029.

Verification
REQ-034 XLEN=64, lb at addr 0x1003, mem_rdata=0x0000_0000_8000_0000 -> mem_addr=0x1000, out_data=0xFFFF_FFFF_FFFF_FF80, out_err=0.
REQ-035 lwu at 0x2004, rdata=0xDEAD_BEEF_0000_0000 -> out_data=0x0000_0000_DEAD_BEEF; lw same -> 0xFFFF_FFFF_DEAD_BEEF.
REQ-036 ld at 0x3006, SUPPORT_MISALIGN=1, lo=0x2211_0000_0000_0000, hi=0x0000_8877_6655_4433 -> two reads (0x3000, 0x3008), out_data=0x8877_6655_4433_2211.
REQ-037 Same ld with SUPPORT_MISALIGN=0, and funct3=111 at 0x0 -> no mem_req, out_valid with out_err=1, out_data=0.
REQ-038 Reset pulsed while in RD1 -> all outputs at reset values; subsequent mem_rvalid produces no out_valid; next request completes normally.
REQ-039 Back-to-back req_valid held high -> second accept only after out_valid; req_ready=0 throughout RD0/RD1/DONE.

Source files
------------

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - RISC-V load alignment unit: word reads, optional split misaligned access, sign/zero extension
module load_align_unit #(
  parameter int XLEN             = 64,
  parameter int ADDR_W           = 64,
  parameter int SUPPORT_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_data,
  output logic              out_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;

  state_t          state, state_nx;
  logic [OFFW-1:0] off_q;
  logic [2:0]      f3_q;
  logic            cross_q;
  logic [XLEN-1:0] lo_q;
  logic            accept;
  logic            req_bad;
  logic            req_cross;
  logic [OFFW-1:0] req_off;

  // Picks bytes [off .. off+size-1] of {hi, lo}; bits above the loaded size
  // take the sign bit for signed loads and zero for unsigned ones.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] hi,
                                              input logic [XLEN-1:0] lo,
                                              input logic [OFFW-1:0] off,
                                              input logic [2:0]      f3);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   res;
    logic              sgn;
    int                bits;
    sh   = {hi, lo} >> {off, 3'b000};
    bits = 8 << f3[1:0];
    sgn  = 1'b0;
    res  = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < bits) begin
        res[i] = sh[i];
        if (i == bits - 1) sgn = sh[i];
      end else begin
        res[i] = sgn & ~f3[2];
      end
    end
    return res;
  endfunction

  always_comb begin
    req_off   = req_addr[OFFW-1:0];
    req_cross = (int'(req_off) + (1 << req_funct3[1:0])) > NB;
    req_bad   = (req_funct3 == 3'b111)
             || ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
             || (req_cross && (SUPPORT_MISALIGN == 0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = req_bad ? DONE : RD0;
        end
      end
      RD0: begin
        mem_req = 1'b1;
        if (mem_rvalid) state_nx = cross_q ? RD1 : DONE;
      end
      RD1: begin
        mem_req = 1'b1;
        if (mem_rvalid) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results are registered on the final read beat so DONE presents them directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_q    <= '0;
      f3_q     <= '0;
      cross_q  <= 1'b0;
      lo_q     <= '0;
      mem_addr <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      if (accept) begin
        off_q   <= req_off;
        f3_q    <= req_funct3;
        cross_q <= req_cross;
        if (req_bad) begin
          out_data <= '0;
          out_err  <= 1'b1;
        end else begin
          mem_addr <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        end
      end
      if ((state == RD0) && mem_rvalid) begin
        lo_q <= mem_rdata;
        if (cross_q) begin
          mem_addr <= mem_addr + ADDR_W'(NB);
        end else begin
          out_data <= extract('0, mem_rdata, off_q, f3_q);
          out_err  <= 1'b0;
        end
      end
      if ((state == RD1) && mem_rvalid) begin
        out_data <= extract(mem_rdata, lo_q, off_q, f3_q);
        out_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - randomized and directed bench for load_align_unit against a byte-level load model
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_err;

  logic        req_valid_nm, req_ready_nm;
  logic [63:0] req_addr_nm;
  logic [2:0]  req_funct3_nm;
  logic        mem_req_nm;
  logic [63:0] mem_addr_nm;
  logic        mem_rvalid_nm;
  logic [63:0] mem_rdata_nm;
  logic        out_valid_nm;
  logic [63:0] out_data_nm;
  logic        out_err_nm;

  int total = 0;
  int bad   = 0;

  bit          stall = 1'b0;
  bit          spur_all = 1'b0;
  logic [63:0] stall_addr = 64'h3008;
  logic [63:0] mem [logic [63:0]];

  always #5 clk = ~clk;

  load_align_unit #(.XLEN(64), .ADDR_W(64), .SUPPORT_MISALIGN(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_data(out_data), .out_err(out_err)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(64), .SUPPORT_MISALIGN(0)) dut_nm (
    .clk(clk), .reset(reset), .req_valid(req_valid_nm), .req_ready(req_ready_nm),
    .req_addr(req_addr_nm), .req_funct3(req_funct3_nm), .mem_req(mem_req_nm), .mem_addr(mem_addr_nm),
    .mem_rvalid(mem_rvalid_nm), .mem_rdata(mem_rdata_nm), .out_valid(out_valid_nm),
    .out_data(out_data_nm), .out_err(out_err_nm)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] memread(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'h9E37_79B9, ~a[31:0] + 32'h1234_5678};
  endfunction

  // Byte-level model: gather size bytes starting at off from lo then hi, then extend.
  function automatic logic [63:0] model_result(input logic [63:0] lo, input logic [63:0] hi,
                                               input logic [63:0] addr, input logic [2:0] f3);
    int          off;
    int          size;
    logic [7:0]  b [16];
    logic [63:0] v;
    off  = int'(addr[2:0]);
    size = 1 << f3[1:0];
    for (int k = 0; k < 8; k++) begin
      b[k]     = lo[8*k +: 8];
      b[k + 8] = hi[8*k +: 8];
    end
    v = 64'h0;
    for (int k = 0; k < size; k++) v = v | (64'(b[off + k]) << (8 * k));
    if (!f3[2] && (size < 8) && v[8*size - 1]) v = v | ({64{1'b1}} << (8 * size));
    return v;
  endfunction

  // Memory responder: random latency, optional stall on one address, spurious beats while idle.
  initial begin
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    mem_rvalid_nm = 1'b0;
    mem_rdata_nm  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !(stall && (mem_addr == stall_addr))) begin
        mem_rvalid = ($urandom_range(0, 2) != 0);
        mem_rdata  = mem_rvalid ? memread(mem_addr) : {$urandom, $urandom};
      end else if (mem_req) begin
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
      end else begin
        mem_rvalid = spur_all || ($urandom_range(0, 3) == 0);
        mem_rdata  = {$urandom, $urandom};
      end
    end
  end

  // Transaction-level scoreboard checked every cycle.
  initial begin
    bit          busy, fin, crs;
    int          need, done_rd, off, size;
    logic [63:0] t_addr, exp_d, last_d;
    logic [2:0]  t_f3;
    logic        exp_e, last_e;
    logic [63:0] w [2];
    busy = 0; fin = 0; need = 0; done_rd = 0;
    t_addr = '0; t_f3 = '0; exp_d = '0; exp_e = 0; last_d = '0; last_e = 0;
    w[0] = '0; w[1] = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_err", out_err, 1'b0);
        busy = 0; fin = 0; last_d = '0; last_e = 0;
      end else begin
        chk("req_ready", req_ready, !busy);
        chk("mem_req", mem_req, busy && !fin && (done_rd < need));
        if (busy && !fin && (done_rd < need))
          chk("mem_addr", mem_addr, (t_addr & ~64'h7) + 64'(8 * done_rd));
        chk("out_valid", out_valid, fin);
        if (fin) begin
          chk("out_data", out_data, exp_d);
          chk("out_err", out_err, exp_e);
          last_d = exp_d;
          last_e = exp_e;
        end else begin
          chk("out_data_hold", out_data, last_d);
          chk("out_err_hold", out_err, last_e);
        end
        if (fin) begin
          busy = 0;
          fin  = 0;
        end else if (!busy) begin
          if (req_valid) begin
            busy    = 1;
            t_addr  = req_addr;
            t_f3    = req_funct3;
            done_rd = 0;
            off     = int'(req_addr[2:0]);
            size    = 1 << req_funct3[1:0];
            crs     = (off + size) > 8;
            if (t_f3 == 3'b111) begin
              need  = 0;
              fin   = 1;
              exp_d = '0;
              exp_e = 1;
            end else begin
              need = crs ? 2 : 1;
            end
          end
        end else if (mem_rvalid) begin
          w[done_rd] = mem_rdata;
          done_rd++;
          if (done_rd == need) begin
            fin   = 1;
            exp_e = 0;
            exp_d = model_result(w[0], (need == 2) ? w[1] : 64'h0, t_addr, t_f3);
          end
        end
      end
    end
  end

  task automatic do_req(input logic [63:0] addr, input logic [2:0] f3,
                        output logic [63:0] data, output logic err,
                        output logic [63:0] a0, output logic [63:0] a1, output int nreads);
    bit acc, got;
    acc = 0; got = 0; nreads = 0;
    data = '0; err = 0; a0 = '0; a1 = '0;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (mem_req && mem_rvalid) begin
        if (nreads == 0) a0 = mem_addr;
        else             a1 = mem_addr;
        nreads++;
      end
      if (out_valid) begin
        got  = 1;
        data = out_data;
        err  = out_err;
      end
    end
    if (!got) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic nm_req(input logic [63:0] addr, input logic [2:0] f3, input string tag);
    int          nvalid;
    bit          saw_req;
    logic [63:0] d;
    logic        e;
    nvalid = 0; saw_req = 0; d = 64'hFFFF; e = 0;
    @(posedge clk);
    #1;
    req_valid_nm  = 1'b1;
    req_addr_nm   = addr;
    req_funct3_nm = f3;
    @(posedge clk);
    #1;
    req_valid_nm = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req_nm) saw_req = 1;
      if (out_valid_nm) begin
        nvalid++;
        d = out_data_nm;
        e = out_err_nm;
      end
    end
    chk({tag, "_nvalid"}, 64'(nvalid), 64'd1);
    chk({tag, "_memreq"}, saw_req, 1'b0);
    chk({tag, "_err"}, e, 1'b1);
    chk({tag, "_data"}, d, 64'h0);
  endtask

  initial begin
    logic [63:0] d, a0, a1;
    logic        e;
    int          n;
    bit          hit;
    req_valid = 0; req_addr = '0; req_funct3 = '0;
    req_valid_nm = 0; req_addr_nm = '0; req_funct3_nm = '0;

    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    chk("pin_lb", model_result(64'h0000_0000_8000_0000, 64'h0, 64'h1003, 3'b000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_lhu_x", model_result(64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 64'h7, 3'b101), 64'h0000_0000_0000_CDAB);
    chk("pin_lh_x", model_result(64'h1200_0000_0000_0000, 64'h0000_0000_0000_0085, 64'h7, 3'b001), 64'hFFFF_FFFF_FFFF_8512);

    mem[64'h1000] = 64'h0000_0000_8000_0000;
    do_req(64'h1003, 3'b000, d, e, a0, a1, n);
    chk("lb_data", d, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_err", e, 1'b0);
    chk("lb_addr", a0, 64'h1000);
    chk("lb_nreads", 64'(n), 64'd1);

    mem[64'h2000] = 64'hDEAD_BEEF_0000_0000;
    do_req(64'h2004, 3'b110, d, e, a0, a1, n);
    chk("lwu_data", d, 64'h0000_0000_DEAD_BEEF);
    do_req(64'h2004, 3'b010, d, e, a0, a1, n);
    chk("lw_data", d, 64'hFFFF_FFFF_DEAD_BEEF);

    mem[64'h3000] = 64'h2211_0000_0000_0000;
    mem[64'h3008] = 64'h0000_8877_6655_4433;
    do_req(64'h3006, 3'b011, d, e, a0, a1, n);
    chk("ld_x_data", d, 64'h8877_6655_4433_2211);
    chk("ld_x_nreads", 64'(n), 64'd2);
    chk("ld_x_a0", a0, 64'h3000);
    chk("ld_x_a1", a1, 64'h3008);

    do_req(64'h0, 3'b111, d, e, a0, a1, n);
    chk("ill_data", d, 64'h0);
    chk("ill_err", e, 1'b1);
    chk("ill_nreads", 64'(n), 64'd0);

    nm_req(64'h3006, 3'b011, "nm_ld_x");
    nm_req(64'h0, 3'b111, "nm_ill");

    // Abort a split load while it waits on its second word.
    stall = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_addr = 64'h3006; req_funct3 = 3'b011;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      hit = mem_req && (mem_addr == 64'h3008);
    end
    chk("rd1_reached", hit, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    stall    = 1'b0;
    spur_all = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("spur_ignored", out_valid, 1'b0);
    end
    spur_all = 1'b0;
    do_req(64'h3006, 3'b011, d, e, a0, a1, n);
    chk("post_rst_data", d, 64'h8877_6655_4433_2211);
    chk("post_rst_err", e, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = 64'h4000 + 64'($urandom_range(0, 63));
      req_funct3 = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
